apb_bus1_ctrl: RTL and testbench

//  Bus[1] APB controller: takes one upstream register request at a time, decodes it against CFG_BUS1_MAP,

---
 rtl/apb_bus1_ctrl_pkg.sv | 63 ++++++
 rtl/apb_bus1_ctrl_if.sv | 29 ++
 rtl/apb_bus1_decoder.sv | 22 ++
 rtl/apb_bus1_ctrl.sv | 148 ++++++++++++++
 tb/tb_apb_bus1_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/apb_bus1_ctrl_pkg.sv
// Bus[1] APB types: slave address map, per-slave APB request/response vectors,
// controller FSM state and shared helpers.
package apb_bus1_ctrl_pkg;

  localparam int unsigned CFG_BUS1_PSLV_TOTAL           = 7;
  localparam int unsigned CFG_BUS1_IDX_W                = 3;
  localparam int unsigned CFG_BUS1_ADDR_W               = 64;
  localparam int unsigned CFG_BUS1_PADDR_W              = 32;
  localparam int unsigned CFG_BUS1_DATA_W               = 32;
  localparam int unsigned CFG_BUS1_STRB_W               = 4;
  localparam int unsigned CFG_BUS1_CTRL_TIMEOUT_DEFAULT = 256;
  localparam int unsigned CFG_BUS1_TMO_W                = 16;

  typedef enum logic [1:0] {
    APB_BUS1_IDLE   = 2'd0,
    APB_BUS1_SETUP  = 2'd1,
    APB_BUS1_ACCESS = 2'd2,
    APB_BUS1_RESP   = 2'd3
  } apb_bus1_ctrl_state_type;

  typedef struct packed {
    logic [CFG_BUS1_ADDR_W-1:0] addr_start;
    logic [CFG_BUS1_ADDR_W-1:0] addr_end;
  } mapinfo_type;

  typedef mapinfo_type bus1_mapinfo_table [CFG_BUS1_PSLV_TOTAL];

  // uart1, PRCI, DMI, SPI, GPIO, DDR, PnP; end address is exclusive
  localparam bus1_mapinfo_table CFG_BUS1_MAP = '{
    '{64'h0000_0000_1001_0000, 64'h0000_0000_1001_1000},
    '{64'h0000_0000_1001_2000, 64'h0000_0000_1001_3000},
    '{64'h0000_0000_1001_E000, 64'h0000_0000_1001_F000},
    '{64'h0000_0000_1005_0000, 64'h0000_0000_1005_1000},
    '{64'h0000_0000_1006_0000, 64'h0000_0000_1006_1000},
    '{64'h0000_0000_100C_0000, 64'h0000_0000_100C_1000},
    '{64'h0000_0000_100F_F000, 64'h0000_0000_1010_0000}
  };

  typedef struct packed {
    logic [CFG_BUS1_PADDR_W-1:0] paddr;
    logic [2:0]                  pprot;
    logic                        psel;
    logic                        penable;
    logic                        pwrite;
    logic [CFG_BUS1_DATA_W-1:0]  pwdata;
    logic [CFG_BUS1_STRB_W-1:0]  pstrb;
  } apb_in_type;

  typedef struct packed {
    logic                       pready;
    logic [CFG_BUS1_DATA_W-1:0] prdata;
    logic                       pslverr;
  } apb_out_type;

  typedef apb_in_type  [CFG_BUS1_PSLV_TOTAL-1:0] bus1_apb_in_vector;
  typedef apb_out_type [CFG_BUS1_PSLV_TOTAL-1:0] bus1_apb_out_vector;

  function automatic logic [CFG_BUS1_PSLV_TOTAL-1:0] bus1_psel_onehot(
      input logic [CFG_BUS1_IDX_W-1:0] idx);
    return CFG_BUS1_PSLV_TOTAL'(1) << idx;
  endfunction

endpackage

// File: rtl/apb_bus1_ctrl_if.sv
// Upstream request/response handshake plus the per-slave APB vectors of Bus[1].
interface apb_bus1_ctrl_if;
  import apb_bus1_ctrl_pkg::*;

  logic                        req_valid;
  logic                        req_ready;
  logic [CFG_BUS1_ADDR_W-1:0]  req_addr;
  logic                        req_write;
  logic [CFG_BUS1_DATA_W-1:0]  req_wdata;
  logic [CFG_BUS1_STRB_W-1:0]  req_wstrb;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [CFG_BUS1_DATA_W-1:0]  resp_rdata;
  logic                        resp_err;
  bus1_apb_in_vector           apbi;
  bus1_apb_out_vector          apbo;

  // Controller side
  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb, resp_ready, apbo,
    output req_ready, resp_valid, resp_rdata, resp_err, apbi
  );

  // Bridge and slave-model side
  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, resp_ready, apbo,
    input  req_ready, resp_valid, resp_rdata, resp_err, apbi
  );
endinterface

// File: rtl/apb_bus1_decoder.sv
// Combinational Bus[1] address decoder over CFG_BUS1_MAP; lowest matching index wins.
module apb_bus1_decoder
  import apb_bus1_ctrl_pkg::*;
(
  input  logic [CFG_BUS1_ADDR_W-1:0] addr,
  output logic                       hit,
  output logic [CFG_BUS1_IDX_W-1:0]  idx
);

  // Scan downwards so a lower-index match overrides a higher one
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = int'(CFG_BUS1_PSLV_TOTAL) - 1; i >= 0; i--) begin
      if ((addr >= CFG_BUS1_MAP[i].addr_start) && (addr < CFG_BUS1_MAP[i].addr_end)) begin
        hit = 1'b1;
        idx = CFG_BUS1_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_bus1_ctrl.sv
// Bus[1] APB controller: one request at a time, SETUP/ACCESS sequencing, one response per request.
// Optional ACCESS-phase abort is built when APB_BUS1_TIMEOUT_EN is defined.
module apb_bus1_ctrl
  import apb_bus1_ctrl_pkg::*;
`ifdef APB_BUS1_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = CFG_BUS1_CTRL_TIMEOUT_DEFAULT
)
`endif
(
  input logic            i_clk,
  input logic            i_rst,
  apb_bus1_ctrl_if.slave bus
);

  apb_bus1_ctrl_state_type state, state_nxt;

  logic                              dec_hit;
  logic [CFG_BUS1_IDX_W-1:0]         dec_idx;
  logic [CFG_BUS1_IDX_W-1:0]         idx_q, idx_nxt;
  logic [CFG_BUS1_PSLV_TOTAL-1:0]    psel_q, psel_nxt;
  logic                              penable_q, penable_nxt;
  logic                              req_ready_q, req_ready_nxt;
  logic                              resp_valid_q, resp_valid_nxt;
  logic [CFG_BUS1_PADDR_W-1:0]       paddr_q;
  logic                              pwrite_q;
  logic [CFG_BUS1_DATA_W-1:0]        pwdata_q;
  logic [CFG_BUS1_STRB_W-1:0]        pstrb_q;
  logic [CFG_BUS1_DATA_W-1:0]        rdata_q;
  logic                              err_q;
  apb_out_type                       sel_c;
  logic                              timeout_c;
  bus1_apb_in_vector                 apbi_c;

  apb_bus1_decoder u_dec (
    .addr (bus.req_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign sel_c = bus.apbo[idx_q];

`ifdef APB_BUS1_TIMEOUT_EN
  logic [CFG_BUS1_TMO_W-1:0] tmo_cnt;
  assign timeout_c = (state == APB_BUS1_ACCESS) && (tmo_cnt == CFG_BUS1_TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state logic; pready beats an expiring timeout
  always_comb begin
    state_nxt = state;
    case (state)
      APB_BUS1_IDLE:   if (bus.req_valid) state_nxt = dec_hit ? APB_BUS1_SETUP : APB_BUS1_RESP;
      APB_BUS1_SETUP:  state_nxt = APB_BUS1_ACCESS;
      APB_BUS1_ACCESS: if (sel_c.pready || timeout_c) state_nxt = APB_BUS1_RESP;
      APB_BUS1_RESP:   if (bus.resp_ready) state_nxt = APB_BUS1_IDLE;
      default:         state_nxt = APB_BUS1_IDLE;
    endcase
  end

  // Output decode from the next state so control outputs leave a register
  always_comb begin
    idx_nxt        = idx_q;
    if ((state == APB_BUS1_IDLE) && bus.req_valid) idx_nxt = dec_idx;
    req_ready_nxt  = (state_nxt == APB_BUS1_IDLE);
    resp_valid_nxt = (state_nxt == APB_BUS1_RESP);
    penable_nxt    = (state_nxt == APB_BUS1_ACCESS);
    psel_nxt       = '0;
    if ((state_nxt == APB_BUS1_SETUP) || (state_nxt == APB_BUS1_ACCESS))
      psel_nxt = bus1_psel_onehot(idx_nxt);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= APB_BUS1_IDLE;
      idx_q        <= '0;
      psel_q       <= '0;
      penable_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
`ifdef APB_BUS1_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      state        <= state_nxt;
      idx_q        <= idx_nxt;
      psel_q       <= psel_nxt;
      penable_q    <= penable_nxt;
      req_ready_q  <= req_ready_nxt;
      resp_valid_q <= resp_valid_nxt;
      case (state)
        APB_BUS1_IDLE: begin
          if (bus.req_valid) begin
            paddr_q  <= bus.req_addr[CFG_BUS1_PADDR_W-1:0];
            pwrite_q <= bus.req_write;
            pwdata_q <= bus.req_wdata;
            pstrb_q  <= bus.req_write ? bus.req_wstrb : '0;
            rdata_q  <= '0;
            err_q    <= ~dec_hit;
          end
        end
        APB_BUS1_ACCESS: begin
          if (sel_c.pready) begin
            rdata_q <= pwrite_q ? '0 : sel_c.prdata;
            err_q   <= sel_c.pslverr;
          end else if (timeout_c) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
`ifdef APB_BUS1_TIMEOUT_EN
      if (state == APB_BUS1_IDLE)
        tmo_cnt <= '0;
      else if ((state == APB_BUS1_ACCESS) && !sel_c.pready)
        tmo_cnt <= tmo_cnt + CFG_BUS1_TMO_W'(1);
`endif
    end
  end

  // Address/data broadcast; select and enable reach only the addressed slave
  always_comb begin
    for (int i = 0; i < int'(CFG_BUS1_PSLV_TOTAL); i++) begin
      apbi_c[i].paddr   = paddr_q;
      apbi_c[i].pprot   = 3'b000;
      apbi_c[i].psel    = psel_q[i];
      apbi_c[i].penable = penable_q & psel_q[i];
      apbi_c[i].pwrite  = pwrite_q;
      apbi_c[i].pwdata  = pwdata_q;
      apbi_c[i].pstrb   = pstrb_q;
    end
  end

  assign bus.apbi       = apbi_c;
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_apb_bus1_ctrl.sv
// Self-checking bench for apb_bus1_ctrl: directed cases plus random traffic against a map/latency model.
module tb_apb_bus1_ctrl;
  import apb_bus1_ctrl_pkg::*;

  localparam int unsigned TB_TMO = 8;
  localparam logic [63:0] MAP_LO [7] = '{64'h1001_0000, 64'h1001_2000, 64'h1001_E000,
                                         64'h1005_0000, 64'h1006_0000, 64'h100C_0000, 64'h100F_F000};
  localparam logic [63:0] MAP_HI [7] = '{64'h1001_1000, 64'h1001_3000, 64'h1001_F000,
                                         64'h1005_1000, 64'h1006_1000, 64'h100C_1000, 64'h1010_0000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_bus1_ctrl_if bus ();

`ifdef APB_BUS1_TIMEOUT_EN
  apb_bus1_ctrl #(.TIMEOUT_CYCLES(TB_TMO)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
`else
  apb_bus1_ctrl dut (.i_clk(clk), .i_rst(rst), .bus(bus));
`endif

  int checks = 0;
  int errors = 0;

  // Slave models: ready after slv_waits ACCESS cycles; noise drives pready/pslverr where it must be ignored
  int          slv_waits = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err   = 1'b0;
  logic        slv_hang  = 1'b0;
  logic [6:0]  noise     = '0;
  int          acc_cnt   = 0;

  always_comb begin
    bus.apbo = '0;
    for (int i = 0; i < 7; i++) begin
      if (bus.apbi[i].psel && bus.apbi[i].penable) begin
        bus.apbo[i].pready  = !slv_hang && (acc_cnt == slv_waits);
        bus.apbo[i].pslverr = slv_err;
      end else begin
        bus.apbo[i].pready  = noise[i];
        bus.apbo[i].pslverr = noise[i];
      end
      bus.apbo[i].prdata = slv_rdata + 32'(i);
    end
  end

  always @(posedge clk) begin
    logic busy;
    busy = 1'b0;
    for (int i = 0; i < 7; i++)
      if (bus.apbi[i].psel && bus.apbi[i].penable && !bus.apbo[i].pready) busy = 1'b1;
    acc_cnt <= busy ? acc_cnt + 1 : 0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_decode(input logic [63:0] addr);
    for (int i = 0; i < 7; i++)
      if (addr >= MAP_LO[i] && addr < MAP_HI[i]) return i;
    return -1;
  endfunction

  function automatic logic [6:0] psel_vec();
    logic [6:0] v;
    for (int i = 0; i < 7; i++) v[i] = bus.apbi[i].psel;
    return v;
  endfunction

  // One request through to response; expectations come from the decode table and APB phase timing
  task automatic run_txn(input logic [63:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] ws, input int waits, input logic [31:0] rd,
                         input logic err, input logic hang, input int hold, input logic [6:0] nz);
    int          idx;
    int          lat;
    int          n;
    logic        seen;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [6:0]  exp_psel;
    idx = ref_decode(addr);
    if (idx < 0) begin
      lat = 1; exp_rd = '0; exp_err = 1'b1;
    end else if (hang) begin
      lat = int'(TB_TMO) + 2; exp_rd = '0; exp_err = 1'b1;
    end else begin
      lat = 3 + waits; exp_rd = wr ? 32'h0 : rd + 32'(idx); exp_err = err;
    end
    @(negedge clk);
    slv_waits = waits; slv_rdata = rd; slv_err = err; slv_hang = hang; noise = nz;
    bus.req_addr = addr; bus.req_write = wr; bus.req_wdata = wd; bus.req_wstrb = ws;
    bus.req_valid = 1'b1;
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 64'(32'($urandom));
    n = 1;
    seen = 1'b0;
    while (n <= 80 && !seen) begin
      exp_psel = '0;
      if (idx >= 0 && n < lat) exp_psel[idx] = 1'b1;
      check("psel", 64'(psel_vec()), 64'(exp_psel));
      if (idx >= 0 && n < lat)
        check("penable", 64'(bus.apbi[idx].penable), 64'(n >= 2));
      if (idx >= 0 && n == 1) begin
        check("paddr",  64'(bus.apbi[idx].paddr), 64'(addr[31:0]));
        check("pwrite", 64'(bus.apbi[idx].pwrite), 64'(wr));
        check("pstrb",  64'(bus.apbi[idx].pstrb), 64'(wr ? ws : 4'h0));
        if (wr) check("pwdata", 64'(bus.apbi[idx].pwdata), 64'(wd));
      end
      if (bus.resp_valid) begin
        seen = 1'b1;
        check("latency", 64'(n), 64'(lat));
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("resp_valid", 64'(bus.resp_valid), 64'd1);
    if (!seen) return;
    for (int h = 0; h <= hold; h++) begin
      check("resp_rdata", 64'(bus.resp_rdata), 64'(exp_rd));
      check("resp_err",   64'(bus.resp_err),   64'(exp_err));
      check("resp_hold",  64'(bus.resp_valid), 64'd1);
      if (h < hold) begin @(posedge clk); #1; end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    noise = '0;
    check("back_idle_ready", 64'(bus.req_ready), 64'd1);
    check("back_idle_valid", 64'(bus.resp_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    int          r;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0;
    bus.req_wdata = '0; bus.req_wstrb = '0; bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready",  64'(bus.req_ready),  64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_rdata",      64'(bus.resp_rdata), 64'd0);
    check("rst_err",        64'(bus.resp_err),   64'd0);
    check("rst_psel",       64'(psel_vec()),     64'd0);
    check("rst_paddr",      64'(bus.apbi[0].paddr), 64'd0);
    @(negedge clk) rst = 1'b0;

    // PRCI read, zero wait states
    run_txn(64'h1001_2004, 1'b0, 32'h0, 4'h0, 0, 32'hA5A5_0000, 1'b0, 1'b0, 0, 7'h00);
    // uart1 write with four wait states
    run_txn(64'h1001_0008, 1'b1, 32'h55, 4'h1, 4, 32'h1234_5678, 1'b0, 1'b0, 0, 7'h00);
    // hole between PRCI and DMI
    run_txn(64'h1001_4000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0, 0, 7'h7F);
    // PnP slave error, then first address past the map end
    run_txn(64'h100F_F000, 1'b0, 32'h0, 4'h0, 1, 32'hDEAD_0000, 1'b1, 1'b0, 0, 7'h00);
    run_txn(64'h1010_0000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0, 0, 7'h00);
`ifdef APB_BUS1_TIMEOUT_EN
    // hung GPIO aborts, PRCI afterwards completes normally
    run_txn(64'h1006_0010, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b1, 0, 7'h00);
    run_txn(64'h1001_2000, 1'b0, 32'h0, 4'h0, 0, 32'h7700_0000, 1'b0, 1'b0, 0, 7'h00);
`endif

    // reset pulse in the middle of an SPI read ACCESS phase
    @(negedge clk);
    slv_waits = 20; slv_hang = 1'b0; slv_err = 1'b0;
    bus.req_addr = 64'h1005_0010; bus.req_write = 1'b0; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("spi_access_psel", 64'(psel_vec()), 64'(7'b000_1000));
    check("spi_access_pen",  64'(bus.apbi[3].penable), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_psel",  64'(psel_vec()), 64'd0);
    check("rst_mid_valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ready", 64'(bus.req_ready), 64'd1);
    check("rst_mid_psel2", 64'(psel_vec()), 64'd0);

    // response held five cycles while upstream is not ready
    run_txn(64'h100C_0020, 1'b0, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 1'b1, 1'b0, 5, 7'h22);

    // random traffic over slaves, region bounds, holes and high-address aliases
    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        case ($urandom_range(0, 3))
          0:       a = MAP_LO[r];
          1:       a = MAP_HI[r] - 64'd1;
          2:       a = MAP_HI[r];
          default: a = MAP_LO[r] + 64'($urandom_range(0, 1023) * 4);
        endcase
      end else if (r == 7) begin
        a = 64'h1001_4000 + 64'($urandom_range(0, 16'hFFFF));
      end else if (r == 8) begin
        a = 64'($urandom_range(0, 32'h1000_FFFF));
      end else begin
        a = {32'h0000_0001, 32'h1001_2004};
      end
      run_txn(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 3)),
              $urandom, 1'($urandom), 1'b0, int'($urandom_range(0, 2)), 7'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
